// File: rtl/spi_master_ctrl.sv
// SPI master for the shared-clock SPI link.
// Takes 10-bit command words over a valid/ready port and sends each one as a
// single SS_n-low frame, MSB first. Frames carry the opcode bit once, then the
// full word. Read-data commands (opcode 2'b11) wait a fixed turnaround, then
// capture one MISO byte and present it with a one-cycle rd_valid pulse.
//
// Host handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on registered state (and
// rst), never on cmd_valid. The host holds cmd_valid and cmd_data until it sees
// the transfer, and may change cmd_data freely afterwards.
module spi_master_ctrl #(
   parameter int TA_CYCLES  = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_data,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_SHIFT = 3'd2,
      S_TURN  = 3'd3,
      S_RECV  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   // Wait counters count down to zero, so they load with length minus one.
   localparam logic [3:0] TA_LOAD  = 4'(TA_CYCLES - 1);
   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [9:0] tx_shift, tx_shift_nxt;
   logic       is_read, is_read_nxt;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;
   logic [7:0] rx_shift, rx_shift_nxt;
   logic       ss_n_nxt;
   logic       mosi_nxt;
   logic [7:0] rd_data_nxt;
   logic       rd_valid_nxt;
   logic       accept;

   assign cmd_ready = (state == S_IDLE) & ~rst;
   assign accept    = cmd_valid & cmd_ready;
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

   // Next-state and next-output logic. SS_n and MOSI are computed for the
   // state being entered, so the registered pins line up with the state they
   // belong to.
   always_comb begin
      state_nxt    = state;
      tx_shift_nxt = tx_shift;
      is_read_nxt  = is_read;
      bit_cnt_nxt  = bit_cnt;
      wait_cnt_nxt = wait_cnt;
      rx_shift_nxt = rx_shift;
      ss_n_nxt     = 1'b1;
      mosi_nxt     = 1'b0;
      rd_data_nxt  = rd_data;
      rd_valid_nxt = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt    = S_CMD;
               tx_shift_nxt = cmd_data;
               is_read_nxt  = (cmd_data[9:8] == 2'b11);
               ss_n_nxt     = 1'b0;
               mosi_nxt     = cmd_data[9];
            end
         end
         S_CMD: begin
            // The opcode bit goes out once here. Then the whole word goes out.
            state_nxt   = S_SHIFT;
            bit_cnt_nxt = 4'd9;
            ss_n_nxt    = 1'b0;
            mosi_nxt    = tx_shift[9];
         end
         S_SHIFT: begin
            if (bit_cnt == 4'd0) begin
               if (is_read) begin
                  state_nxt    = S_TURN;
                  wait_cnt_nxt = TA_LOAD;
                  ss_n_nxt     = 1'b0;
               end else begin
                  state_nxt    = S_GAP;
                  wait_cnt_nxt = GAP_LOAD;
               end
            end else begin
               bit_cnt_nxt  = bit_cnt - 4'd1;
               tx_shift_nxt = {tx_shift[8:0], 1'b0};
               ss_n_nxt     = 1'b0;
               mosi_nxt     = tx_shift[8];
            end
         end
         S_TURN: begin
            ss_n_nxt = 1'b0;
            if (wait_cnt == 4'd0) begin
               state_nxt   = S_RECV;
               bit_cnt_nxt = 4'd7;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_RECV: begin
            rx_shift_nxt[bit_cnt[2:0]] = MISO;
            if (bit_cnt == 4'd0) begin
               // Publish the byte, including this last sample, on entry to GAP.
               state_nxt    = S_GAP;
               wait_cnt_nxt = GAP_LOAD;
               rd_data_nxt  = rx_shift_nxt;
               rd_valid_nxt = 1'b1;
            end else begin
               bit_cnt_nxt = bit_cnt - 4'd1;
               ss_n_nxt    = 1'b0;
            end
         end
         S_GAP: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = S_IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers. Reset drops any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tx_shift <= '0;
         is_read  <= 1'b0;
         bit_cnt  <= '0;
         wait_cnt <= '0;
         rx_shift <= '0;
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         tx_shift <= tx_shift_nxt;
         is_read  <= is_read_nxt;
         bit_cnt  <= bit_cnt_nxt;
         wait_cnt <= wait_cnt_nxt;
         rx_shift <= rx_shift_nxt;
         SS_n     <= ss_n_nxt;
         MOSI     <= mosi_nxt;
         rd_data  <= rd_data_nxt;
         rd_valid <= rd_valid_nxt;
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl. A slave model follows SS_n, drives MISO in the
// receive window, and collects the command word. Per-cycle expectations come
// from frame lengths and bit positions.
module tb_spi_master_ctrl;

   localparam int TA  = 2;
   localparam int GAP = 1;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [9:0] cmd_data = '0;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       busy;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   spi_master_ctrl #(.TA_CYCLES(TA), .GAP_CYCLES(GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_rd = 8'h00;

   // ---------------- slave model ----------------
   logic [7:0] slave_byte  = 8'h00;
   int         low_cnt     = 0;
   int         high_cnt    = 0;
   int         last_high   = 0;
   int         frames_done = 0;
   int         last_len    = 0;
   logic [9:0] rx_acc      = '0;
   logic [9:0] last_rx     = '0;

   // Counts cycles since SS_n fell. Collects the 10-bit word from frame
   // cycles 1..10. Drives the byte MSB first in cycles 11+TA .. 18+TA and
   // noise at all other times.
   always @(negedge clk) begin
      if (SS_n === 1'b0) begin
         if (low_cnt == 0) last_high = high_cnt;
         if (low_cnt >= 1 && low_cnt <= 10) rx_acc = {rx_acc[8:0], MOSI};
         if (low_cnt >= 11 + TA && low_cnt <= 18 + TA) MISO = slave_byte[18 + TA - low_cnt];
         else MISO = 1'($urandom_range(0, 1));
         low_cnt++;
         high_cnt = 0;
      end else begin
         if (low_cnt != 0) begin
            frames_done++;
            last_len = low_cnt;
            last_rx  = rx_acc;
         end
         low_cnt = 0;
         rx_acc  = '0;
         high_cnt++;
         MISO = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(input string who);
      int w = 0;
      while (cmd_ready !== 1'b1 && w < 60) begin
         tick();
         w++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_wait: cmd_ready=%b required 1", who, cmd_ready);
      end
   endtask

   // Sends one command from IDLE. Checks every cycle until the master is
   // idle again.
   task automatic do_frame(input logic [9:0] c, input logic [7:0] mb, input bit toggle);
      bit         rdop;
      int         len, tot, fd0;
      logic [10:0] ev;
      logic [7:0] rd_model;
      rdop     = (c[9:8] == 2'b11);
      len      = rdop ? 11 + TA + 8 : 11;
      tot      = len + GAP;
      ev       = {c[9], c};
      rd_model = exp_rd;
      slave_byte = mb;
      wait_ready("frame");
      if (cmd_ready !== 1'b1) return;
      fd0 = frames_done;
      if (rdop) exp_q.push_back(mb);
      cmd_valid = 1'b1;
      cmd_data  = c;
      tick();
      for (int k = 0; k <= tot; k++) begin
         logic e_ss, e_mosi, e_busy, e_rv;
         e_ss   = (k < len) ? 1'b0 : 1'b1;
         e_mosi = (k <= 10) ? ev[10 - k] : 1'b0;
         e_busy = (k < tot);
         e_rv   = rdop && (k == len);
         if (e_rv && exp_q.size() > 0) rd_model = exp_q.pop_front();
         n_checks++;
         if (SS_n !== e_ss) begin
            n_fail++;
            $display("FAIL ss_n c=%h k=%0d: got %b exp %b", c, k, SS_n, e_ss);
         end
         n_checks++;
         if (MOSI !== e_mosi) begin
            n_fail++;
            $display("FAIL mosi c=%h k=%0d: got %b exp %b", c, k, MOSI, e_mosi);
         end
         n_checks++;
         if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL busy c=%h k=%0d: got %b exp %b", c, k, busy, e_busy);
         end
         n_checks++;
         if (cmd_ready !== !e_busy) begin
            n_fail++;
            $display("FAIL cmd_ready c=%h k=%0d: got %b exp %b", c, k, cmd_ready, !e_busy);
         end
         n_checks++;
         if (rd_valid !== e_rv) begin
            n_fail++;
            $display("FAIL rd_valid c=%h k=%0d: got %b exp %b", c, k, rd_valid, e_rv);
         end
         n_checks++;
         if (rd_data !== rd_model) begin
            n_fail++;
            $display("FAIL rd_data c=%h k=%0d: got %h exp %h", c, k, rd_data, rd_model);
         end
         if (toggle && k < tot) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 10'($urandom);
         end else begin
            cmd_valid = 1'b0;
            cmd_data  = 10'($urandom);
         end
         if (k < tot) tick();
      end
      exp_rd = rd_model;
      n_checks++;
      if (frames_done != fd0 + 1 || last_len != len) begin
         n_fail++;
         $display("FAIL frame_len c=%h: frames %0d len %0d, exp frames %0d len %0d",
                  c, frames_done - fd0, last_len, 1, len);
      end
      n_checks++;
      if (last_rx !== c) begin
         n_fail++;
         $display("FAIL slave_rx: got %h exp %h", last_rx, c);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rd_scoreboard c=%h: %0d reads outstanding, exp 0", c, exp_q.size());
         exp_q.delete();
      end
      if (toggle) begin
         tick();
         n_checks++;
         if (busy !== 1'b0 || SS_n !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_off_accept: busy=%b ss_n=%b exp 0/1", busy, SS_n);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = 10'h0A5;
      repeat (2) tick();
      n_checks++;
      if (SS_n !== 1'b1 || MOSI !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pins: ss_n=%b mosi=%b exp 1/0", SS_n, MOSI);
      end
      n_checks++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rd: rd_data=%h rd_valid=%b exp 00/0", rd_data, rd_valid);
      end
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: busy=%b cmd_ready=%b exp 0/0", busy, cmd_ready);
      end
      rst       = 1'b0;
      cmd_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || SS_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: busy=%b cmd_ready=%b ss_n=%b exp 0/1/1", busy, cmd_ready, SS_n);
      end
      exp_rd = 8'h00;
   endtask

   task automatic test_write_addr();
      do_frame(10'h0A5, 8'($urandom), 1'b0);
   endtask

   task automatic test_read_data();
      do_frame(10'h300, 8'hC3, 1'b0);
      n_checks++;
      if (rd_data !== 8'hC3) begin
         n_fail++;
         $display("FAIL read_c3: rd_data=%h exp c3", rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int t = 0, n_acc = 0, low_rdy = 0, n_rv = 0, w = 0;
      int acc_t[2];
      logic [7:0] b;
      logic [7:0] seen;
      bit will_acc;
      b = 8'($urandom);
      slave_byte = b;
      seen = 8'h00;
      acc_t[0] = 0;
      acc_t[1] = 0;
      wait_ready("b2b");
      cmd_valid = 1'b1;
      cmd_data  = 10'h2FF;
      while (n_acc < 2 && t < 200) begin
         will_acc = (cmd_ready === 1'b1) && cmd_valid;
         if (n_acc == 1 && cmd_ready === 1'b0) low_rdy++;
         tick();
         t++;
         if (will_acc) begin
            acc_t[n_acc] = t;
            n_acc++;
            cmd_data = 10'h3FF;
            if (n_acc == 2) cmd_valid = 1'b0;
         end
      end
      n_checks++;
      if (n_acc != 2 || acc_t[1] - acc_t[0] != 12 + GAP) begin
         n_fail++;
         $display("FAIL b2b_spacing: accepts %0d spacing %0d, exp 2 and %0d",
                  n_acc, acc_t[1] - acc_t[0], 12 + GAP);
      end
      n_checks++;
      if (low_rdy != 11 + GAP) begin
         n_fail++;
         $display("FAIL b2b_ready_low: %0d cycles, exp %0d", low_rdy, 11 + GAP);
      end
      while (busy === 1'b1 && w < 80) begin
         if (rd_valid === 1'b1) begin
            n_rv++;
            seen = rd_data;
         end
         tick();
         w++;
      end
      n_checks++;
      if (n_rv != 1 || seen !== b) begin
         n_fail++;
         $display("FAIL b2b_read: pulses %0d data %h, exp 1 and %h", n_rv, seen, b);
      end
      n_checks++;
      if (last_high != GAP + 1) begin
         n_fail++;
         $display("FAIL b2b_gap: ss_n high %0d cycles, exp %0d", last_high, GAP + 1);
      end
      exp_rd = b;
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] c = 10'h155;
      wait_ready("midrst");
      cmd_valid = 1'b1;
      cmd_data  = c;
      tick();
      cmd_valid = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (SS_n !== 1'b0 || MOSI !== c[4]) begin
         n_fail++;
         $display("FAIL midrst_bit4: ss_n=%b mosi=%b exp 0/%b", SS_n, MOSI, c[4]);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (SS_n !== 1'b1 || MOSI !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_pins: ss_n=%b mosi=%b busy=%b exp 1/0/0", SS_n, MOSI, busy);
      end
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h00 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_rd: rd_valid=%b rd_data=%h cmd_ready=%b exp 0/00/0",
                  rd_valid, rd_data, cmd_ready);
      end
      rst    = 1'b0;
      exp_rd = 8'h00;
      tick();
      do_frame({2'b01, 8'($urandom)}, 8'($urandom), 1'b0);
   endtask

   task automatic test_reset_recv();
      logic [9:0] c;
      do_frame({2'b11, 8'($urandom)}, 8'($urandom_range(1, 255)), 1'b0);
      c = {2'b11, 8'($urandom)};
      wait_ready("recvrst");
      slave_byte = 8'($urandom);
      cmd_valid = 1'b1;
      cmd_data  = c;
      tick();
      cmd_valid = 1'b0;
      repeat (15 + TA) tick();
      n_checks++;
      if (SS_n !== 1'b0 || rd_data !== exp_rd) begin
         n_fail++;
         $display("FAIL recvrst_pre: ss_n=%b rd_data=%h exp 0/%h", SS_n, rd_data, exp_rd);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (SS_n !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL recvrst_post: ss_n=%b rd_valid=%b rd_data=%h busy=%b exp 1/0/00/0",
                  SS_n, rd_valid, rd_data, busy);
      end
      rst    = 1'b0;
      exp_rd = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (rd_valid !== 1'b0 || SS_n !== 1'b1) begin
            n_fail++;
            $display("FAIL recvrst_quiet i=%0d: rd_valid=%b ss_n=%b exp 0/1", i, rd_valid, SS_n);
         end
      end
   endtask

   task automatic test_hold_off();
      do_frame({2'b11, 8'($urandom)}, 8'h5A, 1'b1);
      do_frame(10'h1AA, 8'($urandom), 1'b1);
      n_checks++;
      if (rd_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL hold_off_rd: rd_data=%h exp 5a", rd_data);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         do_frame(10'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_addr();
      test_read_data();
      test_back_to_back();
      test_reset_mid_frame();
      test_reset_recv();
      test_hold_off();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
